// File: rtl/alu_pkg.sv
// Shared encodings for the sequenced ALU controller: ALU ops, command codes,
// controller states and response flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLT = 3'b011
  } alu_op_e;

  typedef enum logic [2:0] {
    CMD_AND = 3'd0,
    CMD_OR  = 3'd1,
    CMD_ADD = 3'd2,
    CMD_SUB = 3'd3,
    CMD_SLT = 3'd4,
    CMD_NOR = 3'd5,
    CMD_ADC = 3'd6,
    CMD_MAX = 3'd7
  } cmd_code_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC1,
    S_EXEC2,
    S_DONE
  } state_e;

  // rsp_flags = {N,V,Z,C}
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alu_cmd_decode.sv
// Combinational command-code decode into ripple-ALU controls.
// MAX shares the SLT encoding because its first pass is a set-less-than.
module alu_cmd_decode
  import alu_pkg::*;
(
  input  logic [2:0] code,
  input  logic       c_flag,
  output logic       ainvert,
  output logic       bnegate,
  output logic       cin,
  output logic [2:0] op
);

  always_comb begin
    ainvert = 1'b0;
    bnegate = 1'b0;
    cin     = 1'b0;
    op      = ALU_AND;
    case (cmd_code_e'(code))
      CMD_AND: op = ALU_AND;
      CMD_OR:  op = ALU_OR;
      CMD_ADD: op = ALU_ADD;
      CMD_SUB: begin
        bnegate = 1'b1;
        cin     = 1'b1;
        op      = ALU_ADD;
      end
      CMD_SLT, CMD_MAX: begin
        bnegate = 1'b1;
        cin     = 1'b1;
        op      = ALU_SLT;
      end
      CMD_NOR: begin
        ainvert = 1'b1;
        bnegate = 1'b1;
        op      = ALU_AND;
      end
      CMD_ADC: begin
        cin = c_flag;
        op  = ALU_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command/response sequencer around an external combinational ripple ALU.
// Single-pass ops take one EXEC cycle; MAX takes an SLT pass then an OR pass.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_code,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_cin,
  output logic         alu_ainvert,
  output logic         alu_bnegate,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_cout,
  input  logic         alu_zero,
  input  logic         alu_overflow
);

  state_e       state_q, state_d;
  cmd_code_e    code_q, code_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;
  logic         c_flag_q, c_flag_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic         alu_cin_q, alu_cin_d;
  logic         alu_ainvert_q, alu_ainvert_d;
  logic         alu_bnegate_q, alu_bnegate_d;
  logic [2:0]   alu_op_q, alu_op_d;

  logic         dec_ainvert;
  logic         dec_bnegate;
  logic         dec_cin;
  logic [2:0]   dec_op;
  logic         accept;
  logic         rsp_fire;
  logic         finish;
  logic [W-1:0] max_sel;

  // ADC carry-in is taken from c_flag_q at accept time; c_flag_q cannot
  // change again until this command's response completes.
  alu_cmd_decode u_decode (
    .code    (cmd_code),
    .c_flag  (c_flag_q),
    .ainvert (dec_ainvert),
    .bnegate (dec_bnegate),
    .cin     (dec_cin),
    .op      (dec_op)
  );

  assign accept   = cmd_valid && cmd_ready_q;
  assign rsp_fire = rsp_valid_q && rsp_ready;
  assign max_sel  = alu_result[0] ? b_q : a_q;

  // ALU drive flops are loaded on the edge entering an EXEC state, so they
  // present the decoded registered command for the whole EXEC cycle.
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    c_flag_d      = c_flag_q;
    alu_a_d       = '0;
    alu_b_d       = '0;
    alu_cin_d     = 1'b0;
    alu_ainvert_d = 1'b0;
    alu_bnegate_d = 1'b0;
    alu_op_d      = ALU_AND;
    finish        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          code_d        = cmd_code_e'(cmd_code);
          a_d           = cmd_a;
          b_d           = cmd_b;
          alu_a_d       = cmd_a;
          alu_b_d       = cmd_b;
          alu_cin_d     = dec_cin;
          alu_ainvert_d = dec_ainvert;
          alu_bnegate_d = dec_bnegate;
          alu_op_d      = dec_op;
          state_d       = S_EXEC1;
        end
      end
      S_EXEC1: begin
        if (code_q == CMD_MAX) begin
          alu_a_d  = max_sel;
          alu_b_d  = max_sel;
          alu_op_d = ALU_OR;
          state_d  = S_EXEC2;
        end else begin
          finish = 1'b1;
        end
      end
      S_EXEC2: finish = 1'b1;
      S_DONE: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          c_flag_d    = rsp_flags_q[FLAG_C];
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      rsp_result_d         = alu_result;
      rsp_flags_d[FLAG_N]  = alu_result[W-1];
      rsp_flags_d[FLAG_V]  = alu_overflow;
      rsp_flags_d[FLAG_Z]  = alu_zero;
      rsp_flags_d[FLAG_C]  = alu_cout;
      rsp_valid_d          = 1'b1;
      state_d              = S_DONE;
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      code_q        <= CMD_AND;
      a_q           <= '0;
      b_q           <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      c_flag_q      <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_cin_q     <= 1'b0;
      alu_ainvert_q <= 1'b0;
      alu_bnegate_q <= 1'b0;
      alu_op_q      <= '0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      a_q           <= a_d;
      b_q           <= b_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      c_flag_q      <= c_flag_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_cin_q     <= alu_cin_d;
      alu_ainvert_q <= alu_ainvert_d;
      alu_bnegate_q <= alu_bnegate_d;
      alu_op_q      <= alu_op_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cin     = alu_cin_q;
  assign alu_ainvert = alu_ainvert_q;
  assign alu_bnegate = alu_bnegate_q;
  assign alu_op      = alu_op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ripple ALU attached.
// Latency is counted as the edge number (accept edge = 0) that samples rsp_valid high.
module tb_alu_seq_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_code;
  logic [W-1:0] cmd_a, cmd_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic [W-1:0] alu_a, alu_b;
  logic         alu_cin, alu_ainvert, alu_bnegate;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_cout, alu_zero, alu_overflow;

  int tests = 0;
  int fails = 0;

  alu_seq_ctrl #(.W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_code     (cmd_code),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cin      (alu_cin),
    .alu_ainvert  (alu_ainvert),
    .alu_bnegate  (alu_bnegate),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
  );

  always #5 clk = ~clk;

  // Behavioural ripple ALU: carry/overflow always come from the adder.
  logic [W-1:0] m_aa, m_bb, m_sum;
  always_comb begin
    m_aa = alu_ainvert ? ~alu_a : alu_a;
    m_bb = alu_bnegate ? ~alu_b : alu_b;
    {alu_cout, m_sum} = {1'b0, m_aa} + {1'b0, m_bb} + {{W{1'b0}}, alu_cin};
    alu_overflow = (m_aa[W-1] == m_bb[W-1]) && (m_sum[W-1] != m_aa[W-1]);
    case (alu_op)
      3'b000:  alu_result = m_aa & m_bb;
      3'b001:  alu_result = m_aa | m_bb;
      3'b010:  alu_result = m_sum;
      3'b011:  alu_result = {{(W-1){1'b0}}, m_sum[W-1] ^ alu_overflow};
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [2:0] code, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_a     = a;
    cmd_b     = b;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic do_cmd(input string tag, input logic [2:0] code, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [5:0] ctrl, input int lat_exp,
                        input logic [W-1:0] res, input logic [3:0] flags);
    int lat;
    issue(tag, code, a, b);
    chk({tag, ".ctrl"}, {26'd0, alu_ainvert, alu_bnegate, alu_cin, alu_op}, {26'd0, ctrl});
    wait_rsp(lat);
    chk({tag, ".lat"}, lat, lat_exp);
    chk({tag, ".res"}, {16'd0, rsp_result}, {16'd0, res});
    chk({tag, ".flags"}, {28'd0, rsp_flags}, {28'd0, flags});
    chk({tag, ".alu_idle"}, {alu_a, alu_b} | {26'd0, alu_ainvert, alu_bnegate, alu_cin, alu_op},
        32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, ".rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_code  = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;

    step();
    chk("rst.ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst.valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.flags", {28'd0, rsp_flags}, 32'd0);
    chk("rst.result", {16'd0, rsp_result}, 32'd0);
    chk("rst.alu_op", {29'd0, alu_op}, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("rst.ready_after", {31'd0, cmd_ready}, 32'd1);

    // ctrl = {ainvert, bnegate, cin, op}
    do_cmd("add_ovf", 3'd2, 16'h7FFF, 16'h0001, 6'b000_010, 2, 16'h8000, 4'b1100);
    do_cmd("sub_zero", 3'd3, 16'h0005, 16'h0005, 6'b011_010, 2, 16'h0000, 4'b0011);
    do_cmd("adc_c1", 3'd6, 16'h0001, 16'h0001, 6'b001_010, 2, 16'h0003, 4'b0000);
    do_cmd("and", 3'd0, 16'h0F0F, 16'h00FF, 6'b000_000, 2, 16'h000F, 4'b0000);
    do_cmd("or", 3'd1, 16'h0F0F, 16'h00FF, 6'b000_001, 2, 16'h0FFF, 4'b0000);
    do_cmd("add_wrap", 3'd2, 16'hFFFF, 16'h0001, 6'b000_010, 2, 16'h0000, 4'b0011);
    do_cmd("max_neg", 3'd7, 16'hFFFE, 16'h0003, 6'b011_011, 3, 16'h0003, 4'b0000);
    do_cmd("max_pos", 3'd7, 16'h0005, 16'h0002, 6'b011_011, 3, 16'h0005, 4'b0000);
    do_cmd("slt", 3'd4, 16'h8000, 16'h0001, 6'b011_011, 2, 16'h0001, 4'b0101);
    do_cmd("nor", 3'd5, 16'h00FF, 16'h0F00, 6'b110_000, 2, 16'hF000, 4'b1001);

    // Backpressure with a competing command held on the channel.
    issue("stall", 3'd2, 16'h1234, 16'h1111);
    wait_rsp(lat);
    chk("stall.lat", lat, 2);
    cmd_valid = 1'b1;
    cmd_code  = 3'd1;
    cmd_a     = 16'hAAAA;
    cmd_b     = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      chk("stall.valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall.result", {16'd0, rsp_result}, 32'h2345);
      chk("stall.ready", {31'd0, cmd_ready}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("stall.drop", {31'd0, rsp_valid}, 32'd0);
    chk("stall.idle", {31'd0, cmd_ready}, 32'd1);
    step();
    step();
    chk("stall.no_queue", {31'd0, rsp_valid}, 32'd0);
    chk("stall.no_queue_rdy", {31'd0, cmd_ready}, 32'd1);

    // Leave C=1 and non-zero flags, then abort a MAX in its second pass.
    do_cmd("sub_again", 3'd3, 16'h0005, 16'h0005, 6'b011_010, 2, 16'h0000, 4'b0011);
    issue("abort", 3'd7, 16'hFFFE, 16'h0003);
    step();
    chk("abort.exec2_op", {29'd0, alu_op}, 32'd1);
    chk("abort.exec2_a", {16'd0, alu_a}, 32'h0003);
    reset = 1'b1;
    step();
    chk("abort.valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort.flags", {28'd0, rsp_flags}, 32'd0);
    chk("abort.result", {16'd0, rsp_result}, 32'd0);
    chk("abort.ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    chk("abort.alu_op", {29'd0, alu_op}, 32'd0);
    reset = 1'b0;
    step();
    chk("abort.ready", {31'd0, cmd_ready}, 32'd1);
    step();
    step();
    chk("abort.no_rsp", {31'd0, rsp_valid}, 32'd0);

    do_cmd("adc_c0", 3'd6, 16'h0001, 16'h0001, 6'b000_010, 2, 16'h0002, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
